// File: rtl/midi_tx.sv
// midi_tx: MIDI UART transmitter (8N1, LSB first, idle high) fed from a FWFT FIFO; optional running-status suppression via RUNNING_STATUS_EN
module midi_tx #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD_RATE = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       fifo_empty_n,
  output logic       fifo_rd,
  output logic       ser_o,
  output logic       busy
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_n;
  logic [7:0]    sh;
  logic          last, skip, go;
  assign last    = cnt == CW'(DIV - 1);
  assign fifo_rd = !reset && fifo_empty_n && (state == IDLE || (state == STOP && last));
  assign go      = fifo_rd && !skip;
`ifdef RUNNING_STATUS_EN
  logic [7:0] rs;
  logic       rs_v, chan;
  assign chan = data_i >= 8'h80 && data_i <= 8'hEF;
  assign skip = chan && rs_v && data_i == rs;
  // track the last channel status byte sent; system common bytes invalidate it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rs   <= 8'h00;
      rs_v <= 1'b0;
    end else if (fifo_rd && chan && !skip) begin
      rs   <= data_i;
      rs_v <= 1'b1;
    end else if (fifo_rd && data_i[7:3] == 5'b11110)
      rs_v <= 1'b0;
`else
  assign skip = 1'b0;
`endif
  // framing FSM: pop in IDLE or the last STOP cycle, then start bit, 8 data bits, stop bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bit_n <= 3'd0;
      sh    <= 8'h00;
      ser_o <= 1'b1;
      busy  <= 1'b0;
    end else begin
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      if (state == IDLE || (state == STOP && last)) begin
        state <= go ? START : IDLE;
        ser_o <= !go;
        busy  <= go;
        if (fifo_rd) sh <= data_i;
      end else if (last && state != STOP) begin
        state <= (state == DATA && bit_n == 3'd7) ? STOP : DATA;
        ser_o <= (state == DATA && bit_n == 3'd7) ? 1'b1 : sh[0];
        sh    <= sh >> 1;
        bit_n <= state == DATA ? bit_n + 3'd1 : 3'd0;
      end
    end
endmodule
